// File: rtl/tart_vis_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : tart_vis_prefetch
//  Description : Bus-domain sequencer that drains the correlator visibility
//                banks after every bank swap. Each enabled switch pulse walks
//                all blocks/words block-major, issuing single bus reads and
//                streaming each result to a valid/ready sink.
//  Option      : TART_PREFETCH_TIMEOUT_EN - adds a TOBITS-wide WAIT-state
//                timeout that aborts the sweep like a bus error.
//  Revision    : 1.0 - initial release
// ============================================================================
module tart_vis_prefetch #(
  parameter int BLOCK  = 24,
  parameter int ABITS  = 14,
  parameter int NBLKS  = 6,
  parameter int WBITS  = 7,
  parameter int COUNT  = 128
`ifdef TART_PREFETCH_TIMEOUT_EN
  ,
  parameter int TOBITS = 8
`endif
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic             switch_i,
  input  logic             clear_i,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic             bst_o,
  output logic [ABITS-1:0] adr_o,
  input  logic             ack_i,
  input  logic             err_i,
  input  logic [BLOCK-1:0] dat_i,
  output logic [BLOCK-1:0] vis_dat_o,
  output logic             vis_vld_o,
  input  logic             vis_rdy_i,
  output logic             vis_last_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             overrun_o,
  output logic             buserr_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_PUSH = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam logic [2:0]       c_last_blk = 3'(NBLKS - 1);
  localparam logic [WBITS-1:0] c_last_wrd = WBITS'(COUNT - 1);

  state_t             state_q, state_d;
  logic [2:0]         blk_q, blk_d;
  logic [WBITS-1:0]   wrd_q, wrd_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;
  logic               buserr_q, buserr_d;
  logic [BLOCK-1:0]   vis_dat_q, vis_dat_d;
  logic               last_word;
  logic               ovr_set;
  logic               err_set;
  logic               to_hit;

  assign last_word = (blk_q == c_last_blk) && (wrd_q == c_last_wrd);

`ifdef TART_PREFETCH_TIMEOUT_EN
  logic [TOBITS-1:0] to_q, to_d;

  // Timeout counter: cleared while requesting, counts every WAIT cycle.
  always_comb begin
    to_d = to_q;
    if (state_q == S_REQ) begin
      to_d = '0;
    end else if (state_q == S_WAIT) begin
      to_d = to_q + TOBITS'(1);
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end

  assign to_hit = (to_q == '1);
`else
  assign to_hit = 1'b0;
`endif

  // Next-state, sweep position, capture and sticky-flag logic.
  always_comb begin
    state_d   = state_q;
    blk_d     = blk_q;
    wrd_d     = wrd_q;
    busy_d    = busy_q;
    vis_dat_d = vis_dat_q;
    err_set   = 1'b0;
    // A pulse arriving mid-sweep is discarded but remembered as an overrun.
    ovr_set   = switch_i && busy_q;

    case (state_q)
      S_IDLE: begin
        if (switch_i && enable_i) begin
          blk_d   = '0;
          wrd_d   = '0;
          busy_d  = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (err_i) begin
          err_set = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Error beats a simultaneous ack; a late ack beats the timeout.
        if (err_i || (to_hit && !ack_i)) begin
          err_set = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (ack_i) begin
          vis_dat_d = dat_i;
          state_d   = S_PUSH;
        end
      end
      S_PUSH: begin
        if (vis_rdy_i) begin
          if (last_word) begin
            busy_d  = 1'b0;
            state_d = S_FIN;
          end else begin
            if (wrd_q == c_last_wrd) begin
              wrd_d = '0;
              blk_d = blk_q + 3'd1;
            end else begin
              wrd_d = wrd_q + WBITS'(1);
            end
            state_d = S_REQ;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Setting a flag takes precedence over clearing it in the same cycle.
    overrun_d = ovr_set | (overrun_q & ~clear_i);
    buserr_d  = err_set | (buserr_q & ~clear_i);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      blk_q     <= '0;
      wrd_q     <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      buserr_q  <= 1'b0;
      vis_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      blk_q     <= blk_d;
      wrd_q     <= wrd_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      buserr_q  <= buserr_d;
      vis_dat_q <= vis_dat_d;
    end
  end

  // Bus and stream outputs decode directly from registered state.
  assign cyc_o      = (state_q == S_REQ) || (state_q == S_WAIT);
  assign stb_o      = cyc_o;
  assign we_o       = 1'b0;
  assign bst_o      = cyc_o && !last_word;
  assign adr_o      = {{(ABITS - WBITS - 3){1'b0}}, blk_q, wrd_q};
  assign vis_vld_o  = (state_q == S_PUSH);
  assign vis_last_o = vis_vld_o && last_word;
  assign vis_dat_o  = vis_dat_q;
  assign busy_o     = busy_q;
  assign done_o     = (state_q == S_FIN);
  assign overrun_o  = overrun_q;
  assign buserr_o   = buserr_q;

endmodule
`default_nettype wire

// File: tb/tb_tart_vis_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tart_vis_prefetch
//  Description : Directed self-checking bench for tart_vis_prefetch
//                (NBLKS=6, COUNT=4). Honours TART_PREFETCH_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tart_vis_prefetch;

  logic        clk_i     = 1'b0;
  logic        rst_n     = 1'b0;
  logic        enable_i  = 1'b1;
  logic        switch_i  = 1'b0;
  logic        clear_i   = 1'b0;
  logic        ack_i     = 1'b0;
  logic        err_i     = 1'b0;
  logic [23:0] dat_i     = 24'h0;
  logic        vis_rdy_i = 1'b1;
  logic        cyc_o, stb_o, we_o, bst_o, vis_vld_o, vis_last_o;
  logic        busy_o, done_o, overrun_o, buserr_o;
  logic [13:0] adr_o;
  logic [23:0] vis_dat_o;

  tart_vis_prefetch #(
`ifdef TART_PREFETCH_TIMEOUT_EN
    .TOBITS(4),
`endif
    .BLOCK(24), .ABITS(14), .NBLKS(6), .WBITS(7), .COUNT(4)
  ) dut (
    .clk_i(clk_i), .rst_n(rst_n), .enable_i(enable_i), .switch_i(switch_i),
    .clear_i(clear_i), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
    .bst_o(bst_o), .adr_o(adr_o), .ack_i(ack_i), .err_i(err_i),
    .dat_i(dat_i), .vis_dat_o(vis_dat_o), .vis_vld_o(vis_vld_o),
    .vis_rdy_i(vis_rdy_i), .vis_last_o(vis_last_o), .busy_o(busy_o),
    .done_o(done_o), .overrun_o(overrun_o), .buserr_o(buserr_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Bench-side environment state (responder + sink monitor).
  int          ncyc = 0, stb_cyc = 0, n_reads = 0, n_words = 0;
  int          done_cnt = 0, busy_cyc = 0, cyc_cyc = 0, viol = 0;
  int          bst_low_cnt = 0, bst_low_idx = 0, last_cnt = 0, last_idx = 0;
  int          err_at = 0, rdy_mode = 0;
  bit          noack = 1'b0, vld_prev = 1'b0;
  logic [13:0] r_adr [64];
  logic [23:0] w_dat [64];
  logic [13:0] err_adr = 14'h0;
  logic [23:0] hold_dat = 24'h0;
  logic        hold_last = 1'b0;

  function automatic logic [23:0] mkdat(input logic [13:0] a);
    return (24'(a) * 24'd4099) ^ 24'h5A5A5A;
  endfunction

  // Expected address of sweep word i: block i/4 at bits [9:7], word i%4.
  function automatic logic [13:0] exp_adr(input int i);
    return 14'(((i / 4) << 7) | (i % 4));
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, act, exp);
  endtask

  // Responder (one-cycle ack latency) and sink, evaluated on the falling edge.
  always @(negedge clk_i) begin
    ncyc++;
    ack_i = 1'b0;
    err_i = 1'b0;
    dat_i = 24'hDEAD00;
    if (cyc_o && stb_o) begin
      stb_cyc++;
      if (stb_cyc == 2 && !noack) begin
        n_reads++;
        if (!bst_o) begin bst_low_cnt++; bst_low_idx = n_reads; end
        if (n_reads == err_at) begin
          err_i = 1'b1; err_adr = adr_o;
        end else begin
          ack_i = 1'b1; dat_i = mkdat(adr_o);
          if (n_reads <= 64) r_adr[n_reads-1] = adr_o;
        end
      end
    end else begin
      stb_cyc = 0;
    end
    case (rdy_mode)
      0:       vis_rdy_i = 1'b1;
      1:       vis_rdy_i = (ncyc % 3 == 0);
      default: vis_rdy_i = (n_words < 4);
    endcase
    if (vis_vld_o) begin
      if (vld_prev && (vis_dat_o !== hold_dat || vis_last_o !== hold_last)) viol++;
      hold_dat  = vis_dat_o;
      hold_last = vis_last_o;
      if (cyc_o) viol++;
      if (vis_rdy_i) begin
        if (n_words < 64) w_dat[n_words] = vis_dat_o;
        if (vis_last_o) begin last_cnt++; last_idx = n_words; end
        n_words++;
      end
    end
    vld_prev = vis_vld_o && !vis_rdy_i;
    if (done_o) done_cnt++;
    if (busy_o) busy_cyc++;
    if (cyc_o)  cyc_cyc++;
  end

  task automatic step();
    @(negedge clk_i); #1;
  endtask

  task automatic clr_mon();
    n_reads = 0; n_words = 0; done_cnt = 0; busy_cyc = 0; cyc_cyc = 0;
    viol = 0; bst_low_cnt = 0; bst_low_idx = 0; last_cnt = 0; last_idx = 0;
  endtask

  task automatic pulse_sw();
    @(posedge clk_i); #1 switch_i = 1'b1;
    @(posedge clk_i); #1 switch_i = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk_i); #1 clear_i = 1'b1;
    @(posedge clk_i); #1 clear_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tg);
    int k = 0;
    step();
    while (busy_o && k < budget) begin step(); k++; end
    check_eq(tg, 32'(busy_o), 32'd0);
    repeat (2) step();
  endtask

  task automatic chk_sweep(input string tg);
    check_eq({tg, "_words"}, 32'(n_words), 32'd24);
    for (int i = 0; i < 24; i++) begin
      check_eq({tg, "_adr"}, 32'(r_adr[i]), 32'(exp_adr(i)));
      check_eq({tg, "_dat"}, 32'(w_dat[i]), 32'(mkdat(exp_adr(i))));
    end
    check_eq({tg, "_last_cnt"}, 32'(last_cnt), 32'd1);
    check_eq({tg, "_last_idx"}, 32'(last_idx), 32'd23);
    check_eq({tg, "_done"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state.
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_ctl", 32'({cyc_o, stb_o, we_o, bst_o, vis_vld_o, vis_last_o,
                             busy_o, done_o, overrun_o, buserr_o}), 32'd0);
    check_eq("rst_adr", 32'(adr_o), 32'd0);
    check_eq("rst_dat", 32'(vis_dat_o), 32'd0);
    @(posedge clk_i); #1 rst_n = 1'b1;

    // Full sweep, sink always ready.
    clr_mon(); rdy_mode = 0;
    pulse_sw();
    wait_idle(200, "t1_idle");
    chk_sweep("t1");
    check_eq("t1_bst_low_cnt", 32'(bst_low_cnt), 32'd1);
    check_eq("t1_bst_low_idx", 32'(bst_low_idx), 32'd24);
    check_eq("t1_busy_cycles", 32'(busy_cyc), 32'd72);
    check_eq("t1_viol", 32'(viol), 32'd0);

    // Same sweep with the sink ready one cycle in three.
    clr_mon(); rdy_mode = 1;
    pulse_sw();
    wait_idle(400, "t2_idle");
    chk_sweep("t2");
    check_eq("t2_stall_viol", 32'(viol), 32'd0);
    rdy_mode = 0;

    // Bus error on the 7th read.
    clr_mon(); err_at = 7;
    pulse_sw();
    wait_idle(200, "t3_idle");
    check_eq("t3_words", 32'(n_words), 32'd6);
    check_eq("t3_err_adr", 32'(err_adr), 32'h082);
    check_eq("t3_buserr", 32'(buserr_o), 32'd1);
    check_eq("t3_done", 32'(done_cnt), 32'd0);
    check_eq("t3_cyc", 32'(cyc_o), 32'd0);
    for (int i = 0; i < 6; i++)
      check_eq("t3_dat", 32'(w_dat[i]), 32'(mkdat(exp_adr(i))));
    clr_mon(); err_at = 0;
    pulse_sw();
    wait_idle(200, "t3b_idle");
    chk_sweep("t3b");
    check_eq("t3b_buserr_sticky", 32'(buserr_o), 32'd1);
    pulse_clr(); step();
    check_eq("t3_buserr_clr", 32'(buserr_o), 32'd0);

    // Overrun: second switch (with a simultaneous clear) during word 10.
    clr_mon();
    pulse_sw();
    for (int k = 0; k < 200 && n_words < 9; k++) step();
    @(posedge clk_i); #1 switch_i = 1'b1; clear_i = 1'b1;
    @(posedge clk_i); #1 switch_i = 1'b0; clear_i = 1'b0;
    step();
    check_eq("t4_overrun_set", 32'(overrun_o), 32'd1);
    wait_idle(200, "t4_idle");
    chk_sweep("t4");
    check_eq("t4_overrun_sticky", 32'(overrun_o), 32'd1);
    @(posedge clk_i); #1 clear_i = 1'b1;
    @(posedge clk_i); #1 clear_i = 1'b0;
    check_eq("t4_overrun_clr", 32'(overrun_o), 32'd0);

    // Asynchronous reset while word 5 is stalled in PUSH.
    clr_mon(); rdy_mode = 2;
    pulse_sw();
    for (int k = 0; k < 200 && !(n_words == 4 && vis_vld_o && !vis_rdy_i); k++) step();
    check_eq("t6_stalled_w5", 32'({vis_vld_o, 4'(n_words)}), 32'h14);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_ctl", 32'({cyc_o, stb_o, bst_o, vis_vld_o, vis_last_o,
                                busy_o, done_o, overrun_o, buserr_o}), 32'd0);
    check_eq("t6_rst_adr", 32'(adr_o), 32'd0);
    check_eq("t6_rst_dat", 32'(vis_dat_o), 32'd0);
    @(posedge clk_i); #1 rst_n = 1'b1; enable_i = 1'b0; rdy_mode = 0;
    pulse_sw();
    repeat (5) step();
    check_eq("t6_dis_busy", 32'(busy_o), 32'd0);
    check_eq("t6_dis_cyc", 32'(cyc_o), 32'd0);
    check_eq("t6_dis_flags", 32'({overrun_o, buserr_o}), 32'd0);
    check_eq("t6_done", 32'(done_cnt), 32'd0);
    enable_i = 1'b1;

    // Responder never acknowledges.
    clr_mon(); noack = 1'b1;
    pulse_sw();
`ifdef TART_PREFETCH_TIMEOUT_EN
    wait_idle(60, "t5_to_idle");
    check_eq("t5_buserr", 32'(buserr_o), 32'd1);
    check_eq("t5_cyc_cycles", 32'(cyc_cyc), 32'd17);
    check_eq("t5_done", 32'(done_cnt), 32'd0);
`else
    repeat (1000) step();
    check_eq("t5_cyc_held", 32'(cyc_o), 32'd1);
    check_eq("t5_busy_held", 32'(busy_o), 32'd1);
    check_eq("t5_no_buserr", 32'(buserr_o), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
